// File: rtl/id_rom_arbiter.sv
// Round-robin arbiter sharing one 32x16 player-ID ROM between the ID check (port 0)
// and the profile lookup (port 1); waits out the ROM latency and returns the word with a one-cycle ack.
module id_rom_arbiter #(
    parameter int unsigned ROM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [4:0]  addr0,
    input  logic        req1,
    input  logic [4:0]  addr1,
    output logic [4:0]  ROM_addr,
    input  logic [15:0] ROM_data,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic        busy
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] LAST_WAIT = CW'(ROM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt;
    logic          r_owner;
    logic          w_owner;
    logic          r_prio;
    logic          w_prio;
    logic [AW-1:0] r_rom_addr;
    logic [AW-1:0] w_rom_addr;
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] w_rdata;
    logic          r_ack0;
    logic          w_ack0;
    logic          r_ack1;
    logic          w_ack1;
    logic          r_busy;
    logic          w_busy;
    logic          w_winner;

    // Only one requester: it wins outright; both: the priority pointer decides.
    always_comb begin
        w_winner = 1'b0;
        if (req0 && req1) begin
            w_winner = r_prio;
        end else if (req1) begin
            w_winner = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_owner    <= 1'b0;
            r_prio     <= 1'b0;
            r_rom_addr <= '0;
            r_rdata    <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_owner    <= w_owner;
            r_prio     <= w_prio;
            r_rom_addr <= w_rom_addr;
            r_rdata    <= w_rdata;
            r_ack0     <= w_ack0;
            r_ack1     <= w_ack1;
            r_busy     <= w_busy;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_owner    = r_owner;
        w_prio     = r_prio;
        w_rom_addr = r_rom_addr;
        w_rdata    = r_rdata;
        w_ack0     = 1'b0;
        w_ack1     = 1'b0;
        w_busy     = r_busy;

        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (req0 || req1) begin
                    w_rom_addr = w_winner ? addr1 : addr0;
                    w_owner    = w_winner;
                    w_prio     = ~w_winner;
                    w_cnt      = '0;
                    w_busy     = 1'b1;
                    w_state    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == LAST_WAIT) begin
                    w_state = S_CAPTURE;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_CAPTURE: begin
                w_rdata = ROM_data;
                w_ack0  = ~r_owner;
                w_ack1  = r_owner;
                w_state = S_DONE;
            end
            S_DONE: begin
                // Requests are deliberately not sampled here; a held req is served next cycle.
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign ROM_addr = r_rom_addr;
    assign rdata    = r_rdata;
    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign busy     = r_busy;

endmodule

// File: tb/tb_id_rom_arbiter.sv
// Bench for id_rom_arbiter: two instances (latency 2 and 4) against a transaction-level
// model that predicts each grant's ack/idle cycles from the acceptance cycle.
module tb_id_rom_arbiter;

    localparam int unsigned LAT0 = 2;
    localparam int unsigned LAT1 = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0 [2];
    logic        req1 [2];
    logic [4:0]  addr0 [2];
    logic [4:0]  addr1 [2];
    logic [4:0]  rom_addr [2];
    logic [15:0] rom_data [2];
    logic [15:0] rdata [2];
    logic        ack0 [2];
    logic        ack1 [2];
    logic        busy [2];

    logic [15:0] mem [32];
    logic [4:0]  pa [2][4];

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int ack_cyc  = 0;
    int c0       = 0;
    int g  [$];
    int rd [$];

    // Reference model state: acceptance cycle, next legal acceptance cycle, owner, priority.
    int          m_acc [2];
    int          m_next_ok [2];
    logic        m_owner [2];
    logic        m_prio [2];
    logic [4:0]  m_addr [2];
    logic [15:0] m_rdata [2];

    always #5 clk = ~clk;

    id_rom_arbiter #(.ROM_LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req0(req0[0]), .addr0(addr0[0]), .req1(req1[0]), .addr1(addr1[0]),
        .ROM_addr(rom_addr[0]), .ROM_data(rom_data[0]),
        .ack0(ack0[0]), .ack1(ack1[0]), .rdata(rdata[0]), .busy(busy[0])
    );

    id_rom_arbiter #(.ROM_LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0(req0[1]), .addr0(addr0[1]), .req1(req1[1]), .addr1(addr1[1]),
        .ROM_addr(rom_addr[1]), .ROM_data(rom_data[1]),
        .ack0(ack0[1]), .ack1(ack1[1]), .rdata(rdata[1]), .busy(busy[1])
    );

    // ROM with an L-cycle address pipeline per instance.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            pa[d][0] <= rom_addr[d];
            for (int k = 1; k < 4; k++) pa[d][k] <= pa[d][k-1];
        end
    end
    assign rom_data[0] = mem[pa[0][LAT0-1]];
    assign rom_data[1] = mem[pa[1][LAT1-1]];

    function automatic int lat(input int d);
        return (d == 0) ? int'(LAT0) : int'(LAT1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_acc[d]     = -100;
            m_next_ok[d] = 0;
            m_owner[d]   = 1'b0;
            m_prio[d]    = 1'b0;
            m_addr[d]    = '0;
            m_rdata[d]   = '0;
        end
    endtask

    task automatic model_edge(input int n);
        int  l;
        logic w;
        for (int d = 0; d < 2; d++) begin
            l = lat(d);
            if (rst) begin
                m_acc[d]     = -100;
                m_next_ok[d] = 0;
                m_owner[d]   = 1'b0;
                m_prio[d]    = 1'b0;
                m_addr[d]    = '0;
                m_rdata[d]   = '0;
            end else begin
                if (n == m_acc[d] + l + 1) m_rdata[d] = mem[m_addr[d]];
                if (n >= m_next_ok[d] && (req0[d] || req1[d])) begin
                    w = (req0[d] && req1[d]) ? m_prio[d] : req1[d];
                    m_owner[d]   = w;
                    m_addr[d]    = w ? addr1[d] : addr0[d];
                    m_prio[d]    = ~w;
                    m_acc[d]     = n;
                    m_next_ok[d] = n + l + 3;
                end
            end
        end
    endtask

    task automatic check_dut(input int d);
        int   l;
        logic e_ack;
        logic e_busy;
        l      = lat(d);
        e_ack  = (cyc == m_acc[d] + l + 1);
        e_busy = (cyc >= m_acc[d]) && (cyc < m_acc[d] + l + 2);
        chk($sformatf("d%0d ack0 cyc%0d", d, cyc), 32'(ack0[d]), 32'(e_ack && !m_owner[d]));
        chk($sformatf("d%0d ack1 cyc%0d", d, cyc), 32'(ack1[d]), 32'(e_ack && m_owner[d]));
        chk($sformatf("d%0d busy cyc%0d", d, cyc), 32'(busy[d]), 32'(e_busy));
        chk($sformatf("d%0d rdata cyc%0d", d, cyc), 32'(rdata[d]), 32'(m_rdata[d]));
        chk($sformatf("d%0d rom_addr cyc%0d", d, cyc), 32'(rom_addr[d]), 32'(m_addr[d]));
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge(cyc);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    // Step until `count` acks from instance d; drop the acked req unless hold is set.
    task automatic run_acks(input int d, input int count, input bit hold, input int max_cyc);
        int k;
        k = 0;
        g.delete();
        rd.delete();
        while (g.size() < count && k < max_cyc) begin
            step();
            k++;
            if (ack0[d] === 1'b1) begin
                g.push_back(0); rd.push_back(int'(rdata[d])); ack_cyc = cyc;
                if (!hold) req0[d] = 1'b0;
            end
            if (ack1[d] === 1'b1) begin
                g.push_back(1); rd.push_back(int'(rdata[d])); ack_cyc = cyc;
                if (!hold) req1[d] = 1'b0;
            end
        end
        chk($sformatf("d%0d ack count", d), 32'(g.size()), 32'(count));
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req0[d] = 1'b0; req1[d] = 1'b0; addr0[d] = '0; addr1[d] = '0;
        end
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
        mem[1]  = 16'h0A01;
        mem[2]  = 16'h0B02;
        mem[3]  = 16'h1234;
        mem[31] = 16'hFFFF;
        model_reset();
        #1;
        check_dut(0);
        check_dut(1);

        // Simultaneous requests from reset: port 0 first, then port 1.
        req0[0] = 1'b1; addr0[0] = 5'd1;
        req1[0] = 1'b1; addr1[0] = 5'd2;
        step();
        step();
        rst = 1'b0;
        run_acks(0, 2, 1'b0, 20);
        chk("sim first port", 32'(g[0]), 32'd0);
        chk("sim first word", 32'(rd[0]), 32'h0A01);
        chk("sim second port", 32'(g[1]), 32'd1);
        chk("sim second word", 32'(rd[1]), 32'h0B02);
        repeat (3) step();
        chk("sim rdata holds", 32'(rdata[0]), 32'h0B02);

        // Single request, L=2.
        req0[0] = 1'b1; addr0[0] = 5'h03;
        step();
        chk("single rom_addr", 32'(rom_addr[0]), 32'h3);
        chk("single busy E0", 32'(busy[0]), 32'd1);
        step();
        step();
        chk("single no early ack", 32'(ack0[0]), 32'd0);
        step();
        chk("single ack0", 32'(ack0[0]), 32'd1);
        chk("single rdata", 32'(rdata[0]), 32'h1234);
        chk("single ack1 quiet", 32'(ack1[0]), 32'd0);
        req0[0] = 1'b0;
        step();
        chk("single busy E4", 32'(busy[0]), 32'd0);
        chk("single ack0 E4", 32'(ack0[0]), 32'd0);
        repeat (2) step();

        // Asynchronous reset mid-WAIT, then a fresh transaction with req0 still high.
        req0[0] = 1'b1; addr0[0] = 5'h07;
        step();
        step();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async busy", 32'(busy[0]), 32'd0);
        chk("async rom_addr", 32'(rom_addr[0]), 32'd0);
        chk("async rdata", 32'(rdata[0]), 32'd0);
        chk("async acks", 32'({ack0[0], ack1[0]}), 32'd0);
        step();
        rst = 1'b0;
        c0 = cyc + 1;
        run_acks(0, 1, 1'b0, 10);
        chk("post-reset ack latency", 32'(ack_cyc - c0), 32'd3);
        chk("post-reset word", 32'(rd[0]), 32'(mem[7]));
        repeat (2) step();
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;

        // Fairness: both held high across six grants.
        req0[0] = 1'b1; addr0[0] = 5'd4;
        req1[0] = 1'b1; addr1[0] = 5'd5;
        run_acks(0, 6, 1'b1, 60);
        for (int i = 0; i < 6; i++) chk($sformatf("fair grant %0d", i), 32'(g[i]), 32'(i % 2));
        req0[0] = 1'b0; req1[0] = 1'b0;
        repeat (3) step();

        // Latency 4 instance.
        req1[1] = 1'b1; addr1[1] = 5'h1F;
        c0 = cyc + 1;
        run_acks(1, 1, 1'b0, 12);
        chk("L4 ack latency", 32'(ack_cyc - c0), 32'd5);
        chk("L4 port", 32'(g[0]), 32'd1);
        chk("L4 word", 32'(rd[0]), 32'hFFFF);
        repeat (3) step();

        // Abandoned request: req1 dropped during WAIT still gets its ack, nothing follows.
        req1[0] = 1'b1; addr1[0] = 5'h09;
        step();
        step();
        req1[0] = 1'b0;
        run_acks(0, 1, 1'b0, 6);
        chk("abandon port", 32'(g[0]), 32'd1);
        repeat (5) step();
        chk("abandon idle busy", 32'(busy[0]), 32'd0);

        // Random traffic on both instances with occasional drops and resets.
        for (int t = 0; t < 600; t++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                if (req0[d]) begin
                    if (ack0[d] || $urandom_range(0, 29) == 0) req0[d] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req0[d] = 1'b1; addr0[d] = 5'($urandom);
                end
                if (req1[d]) begin
                    if (ack1[d] || $urandom_range(0, 29) == 0) req1[d] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req1[d] = 1'b1; addr1[d] = 5'($urandom);
                end
            end
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                check_dut(0);
                check_dut(1);
                step();
                rst = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
